// File: rtl/axi_stream_extract_header_if.sv
// Signal bundle for the header extractor: input stream, header port, payload stream, error pulse.
// slave is the extractor side; master is the upstream/downstream environment side.
interface axi_stream_extract_header_if;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic [1:0]  byte_extract_cnt;

    logic        valid_header;
    logic        ready_header;
    logic [31:0] data_header;
    logic [3:0]  keep_header;

    logic        valid_out;
    logic        ready_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;

    logic        err_keep;

    modport slave (
        input  valid_in, data_in, keep_in, last_in, byte_extract_cnt,
        input  ready_header, ready_out,
        output ready_in,
        output valid_header, data_header, keep_header,
        output valid_out, data_out, keep_out, last_out,
        output err_keep
    );

    modport master (
        output valid_in, data_in, keep_in, last_in, byte_extract_cnt,
        output ready_header, ready_out,
        input  ready_in,
        input  valid_header, data_header, keep_header,
        input  valid_out, data_out, keep_out, last_out,
        input  err_keep
    );
endinterface

// File: rtl/axi_stream_extract_header.sv
// Strips a 1-4 byte header off each 32-bit MSB-first packet and realigns the payload to lane 3.
// Latency: one cycle input-to-payload; header valid on the edge accepting the first beat.
// Backpressure: first beat waits for a free header slot, body beats for a free output register.
module axi_stream_extract_header (
    input  logic                          clk,
    input  logic                          rst,
    axi_stream_extract_header_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, BODY, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [31:0] hold, hold_nxt;
    logic [2:0]  hold_cnt, hold_cnt_nxt;
    logic [2:0]  h_len, h_len_nxt;

    logic [31:0] dout_nxt, dhdr_nxt;
    logic [3:0]  kout_nxt, khdr_nxt;
    logic        lout_nxt, vout_nxt, vhdr_nxt, err_nxt;

    logic        out_free, hdr_free, ready_int, accept, keep_bad;
    logic [2:0]  n_in, h_cur, r_cur, n_hdr, tot, extra;
    logic [31:0] data_msk, joined, tail;

    function automatic logic [3:0] keep_of(input logic [2:0] cnt);
        case (cnt)
            3'd0:    keep_of = 4'b0000;
            3'd1:    keep_of = 4'b1000;
            3'd2:    keep_of = 4'b1100;
            3'd3:    keep_of = 4'b1110;
            default: keep_of = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input logic [2:0] cnt);
        logic [3:0] k;
        k = keep_of(cnt);
        lane_mask = {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

    // Illegal keep patterns are treated as a full beat and flagged.
    always_comb begin
        keep_bad = 1'b0;
        case (bus.keep_in)
            4'b1000: n_in = 3'd1;
            4'b1100: n_in = 3'd2;
            4'b1110: n_in = 3'd3;
            4'b1111: n_in = 3'd4;
            default: begin
                n_in     = 3'd4;
                keep_bad = 1'b1;
            end
        endcase
    end

    assign out_free = !bus.valid_out || bus.ready_out;
    assign hdr_free = !bus.valid_header || bus.ready_header;

    always_comb begin
        ready_int = 1'b0;
        case (state)
            IDLE:    ready_int = hdr_free;
            BODY:    ready_int = out_free;
            default: ready_int = 1'b0;
        endcase
        if (rst) ready_int = 1'b0;
    end

    assign bus.ready_in = ready_int;
    assign accept       = bus.valid_in && ready_int;

    // H is taken from the port only on the first beat; later beats use the latched copy.
    assign h_cur    = (state == IDLE) ? ({1'b0, bus.byte_extract_cnt} + 3'd1) : h_len;
    assign r_cur    = 3'd4 - h_cur;
    assign data_msk = bus.data_in & lane_mask(n_in);
    assign joined   = hold | (data_msk >> {r_cur, 3'b000});
    assign tail     = data_msk << {h_cur, 3'b000};
    assign n_hdr    = (n_in < h_cur) ? n_in : h_cur;
    assign tot      = r_cur + n_in;
    assign extra    = n_in - h_cur;

    always_comb begin
        state_nxt    = state;
        hold_nxt     = hold;
        hold_cnt_nxt = hold_cnt;
        h_len_nxt    = h_len;
        dout_nxt     = bus.data_out;
        kout_nxt     = bus.keep_out;
        lout_nxt     = bus.last_out;
        vout_nxt     = bus.valid_out && !bus.ready_out;
        dhdr_nxt     = bus.data_header;
        khdr_nxt     = bus.keep_header;
        vhdr_nxt     = bus.valid_header && !bus.ready_header;
        err_nxt      = accept && (keep_bad || (!bus.last_in && bus.keep_in != 4'b1111));

        case (state)
            IDLE: begin
                if (accept) begin
                    h_len_nxt = h_cur;
                    dhdr_nxt  = data_msk & lane_mask(n_hdr);
                    khdr_nxt  = keep_of(n_hdr);
                    vhdr_nxt  = 1'b1;
                    if (!bus.last_in) begin
                        hold_nxt     = tail;
                        hold_cnt_nxt = r_cur;
                        state_nxt    = BODY;
                    end else if (n_in > h_cur) begin
                        hold_nxt     = tail;
                        hold_cnt_nxt = extra;
                        state_nxt    = FLUSH;
                    end
                end
            end
            BODY: begin
                if (accept) begin
                    vout_nxt = 1'b1;
                    if (!bus.last_in) begin
                        dout_nxt     = joined;
                        kout_nxt     = 4'b1111;
                        lout_nxt     = 1'b0;
                        hold_nxt     = tail;
                        hold_cnt_nxt = r_cur;
                    end else if (n_in <= h_cur) begin
                        dout_nxt     = joined & lane_mask(tot);
                        kout_nxt     = keep_of(tot);
                        lout_nxt     = 1'b1;
                        hold_nxt     = '0;
                        hold_cnt_nxt = '0;
                        state_nxt    = IDLE;
                    end else begin
                        dout_nxt     = joined;
                        kout_nxt     = 4'b1111;
                        lout_nxt     = 1'b0;
                        hold_nxt     = tail;
                        hold_cnt_nxt = extra;
                        state_nxt    = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    dout_nxt     = hold;
                    kout_nxt     = keep_of(hold_cnt);
                    lout_nxt     = 1'b1;
                    vout_nxt     = 1'b1;
                    hold_nxt     = '0;
                    hold_cnt_nxt = '0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            hold             <= '0;
            hold_cnt         <= '0;
            h_len            <= 3'd4;
            bus.valid_out    <= 1'b0;
            bus.data_out     <= '0;
            bus.keep_out     <= '0;
            bus.last_out     <= 1'b0;
            bus.valid_header <= 1'b0;
            bus.data_header  <= '0;
            bus.keep_header  <= '0;
            bus.err_keep     <= 1'b0;
        end else begin
            state            <= state_nxt;
            hold             <= hold_nxt;
            hold_cnt         <= hold_cnt_nxt;
            h_len            <= h_len_nxt;
            bus.valid_out    <= vout_nxt;
            bus.data_out     <= dout_nxt;
            bus.keep_out     <= kout_nxt;
            bus.last_out     <= lout_nxt;
            bus.valid_header <= vhdr_nxt;
            bus.data_header  <= dhdr_nxt;
            bus.keep_header  <= khdr_nxt;
            bus.err_keep     <= err_nxt;
        end
    end
endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Bench for axi_stream_extract_header: directed test-plan packets with literal expectations,
// then random packets checked against a byte-queue reference model under random backpressure.
module tb_axi_stream_extract_header;
    logic clk = 1'b0;
    logic rst;

    axi_stream_extract_header_if bus();

    axi_stream_extract_header dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t      exp_pay[$], obs_pay[$], exp_hdr[$], obs_hdr[$];
    logic [7:0] pkt[$];
    int         n_assert = 0;
    int         n_fail = 0;
    int         stall_viol = 0;
    int         pp = 0;
    int         ph = 0;
    int         out_mode = 0;
    int         hdr_mode = 0;

    beat_t prev_p, prev_h;
    logic  stall_p = 1'b0;
    logic  stall_h = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ready generators: 0 = always ready, 1 = random, 2 = held low.
    initial begin
        bus.ready_out    = 1'b1;
        bus.ready_header = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.ready_out    = (out_mode == 0) ? 1'b1 : (out_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.ready_header = (hdr_mode == 0) ? 1'b1 : (hdr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor: collects transferred beats and flags any change while stalled.
    always @(negedge clk) begin
        if (rst) begin
            stall_p <= 1'b0;
            stall_h <= 1'b0;
        end else begin
            if ((stall_p && (!bus.valid_out || {bus.data_out, bus.keep_out, bus.last_out} !== prev_p)) ||
                (stall_h && (!bus.valid_header || {bus.data_header, bus.keep_header, 1'b0} !== prev_h)))
                stall_viol <= stall_viol + 1;
            if (bus.valid_out && bus.ready_out)
                obs_pay.push_back({bus.data_out, bus.keep_out, bus.last_out});
            if (bus.valid_header && bus.ready_header)
                obs_hdr.push_back({bus.data_header, bus.keep_header, 1'b0});
            stall_p <= bus.valid_out && !bus.ready_out;
            stall_h <= bus.valid_header && !bus.ready_header;
            prev_p  <= {bus.data_out, bus.keep_out, bus.last_out};
            prev_h  <= {bus.data_header, bus.keep_header, 1'b0};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [1:0] c);
        logic acc;
        acc                  = 1'b0;
        bus.valid_in         = 1'b1;
        bus.data_in          = d;
        bus.keep_in          = k;
        bus.last_in          = l;
        bus.byte_extract_cnt = c;
        for (int t = 0; t < 400 && !acc; t++) begin
            @(negedge clk);
            acc = bus.ready_in;
        end
        chk("in_accept", 64'(acc), 64'd1);
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic add_word(input logic [31:0] w, input int nbytes);
        for (int j = 0; j < nbytes; j++) pkt.push_back(w[31-8*j -: 8]);
    endtask

    // Invalid lanes carry random garbage; the DUT must zero them.
    task automatic send_pkt(input int h);
        int len;
        int nb;
        len = pkt.size();
        nb  = (len + 3) / 4;
        for (int b = 0; b < nb; b++) begin
            logic [31:0] d;
            logic [3:0]  k;
            int          cnt;
            d   = $urandom;
            k   = 4'b0000;
            cnt = (len - 4 * b > 4) ? 4 : len - 4 * b;
            for (int j = 0; j < cnt; j++) begin
                d[31-8*j -: 8] = pkt[4*b+j];
                k[3-j]         = 1'b1;
            end
            send_beat(d, k, b == nb - 1, (b == 0) ? 2'(h - 1) : 2'($urandom_range(0, 3)));
        end
    endtask

    // Reference: header is the first min(len,H) bytes, payload the rest in 4-byte chunks.
    task automatic model_pkt(input int h);
        int    len;
        int    hl;
        beat_t b;
        len = pkt.size();
        hl  = (len < h) ? len : h;
        b   = '0;
        for (int j = 0; j < hl; j++) begin
            b.d[31-8*j -: 8] = pkt[j];
            b.k[3-j]         = 1'b1;
        end
        exp_hdr.push_back(b);
        for (int s = hl; s < len; s += 4) begin
            b = '0;
            for (int j = 0; j < 4 && s + j < len; j++) begin
                b.d[31-8*j -: 8] = pkt[s+j];
                b.k[3-j]         = 1'b1;
            end
            b.l = (s + 4 >= len);
            exp_pay.push_back(b);
        end
    endtask

    task automatic exp_h(input logic [31:0] d, input logic [3:0] k);
        exp_hdr.push_back({d, k, 1'b0});
    endtask

    task automatic exp_p(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_pay.push_back({d, k, l});
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((obs_pay.size() < exp_pay.size() || obs_hdr.size() < exp_hdr.size()) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (8) @(posedge clk);
        #1;
        chk({tag, "_npay"}, 64'(obs_pay.size()), 64'(exp_pay.size()));
        chk({tag, "_nhdr"}, 64'(obs_hdr.size()), 64'(exp_hdr.size()));
        for (; pp < exp_pay.size() && pp < obs_pay.size(); pp++)
            chk({tag, "_pay"}, 64'(obs_pay[pp]), 64'(exp_pay[pp]));
        for (; ph < exp_hdr.size() && ph < obs_hdr.size(); ph++)
            chk({tag, "_hdr"}, 64'(obs_hdr[ph]), 64'(exp_hdr[ph]));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid_out"},    64'(bus.valid_out),    64'd0);
        chk({tag, "_data_out"},     64'(bus.data_out),     64'd0);
        chk({tag, "_keep_out"},     64'(bus.keep_out),     64'd0);
        chk({tag, "_last_out"},     64'(bus.last_out),     64'd0);
        chk({tag, "_valid_header"}, 64'(bus.valid_header), 64'd0);
        chk({tag, "_data_header"},  64'(bus.data_header),  64'd0);
        chk({tag, "_keep_header"},  64'(bus.keep_header),  64'd0);
        chk({tag, "_err_keep"},     64'(bus.err_keep),     64'd0);
    endtask

    initial begin
        rst                  = 1'b1;
        bus.valid_in         = 1'b0;
        bus.data_in          = '0;
        bus.keep_in          = '0;
        bus.last_in          = 1'b0;
        bus.byte_extract_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_in", 64'(bus.ready_in), 64'd0);
        check_reset_outputs("rst");
        rst = 1'b0;
        #1;
        chk("post_rst_ready_in", 64'(bus.ready_in), 64'd1);

        // H=2, two full beats
        pkt.delete(); add_word(32'hAABBCCDD, 4); add_word(32'h11223344, 4);
        send_pkt(2);
        exp_h(32'hAABB0000, 4'b1100);
        exp_p(32'hCCDD1122, 4'b1111, 1'b0);
        exp_p(32'h33440000, 4'b1100, 1'b1);
        drain("h2");

        // H=4, pass-through of the payload beat
        pkt.delete(); add_word(32'hAABBCCDD, 4); add_word(32'h11220000, 2);
        send_pkt(4);
        exp_h(32'hAABBCCDD, 4'b1111);
        exp_p(32'h11220000, 4'b1100, 1'b1);
        drain("h4");

        // H=3, single beat with one payload byte
        pkt.delete(); add_word(32'hAABBCCDD, 4);
        send_pkt(3);
        exp_h(32'hAABBCC00, 4'b1110);
        exp_p(32'hDD000000, 4'b1000, 1'b1);
        drain("h3_single");

        // H=4, single short beat: header only
        pkt.delete(); add_word(32'hAABBCC00, 3);
        send_pkt(4);
        exp_h(32'hAABBCC00, 4'b1110);
        drain("h4_short");

        // Illegal keep: one-cycle err pulse, beat treated as four bytes
        send_beat(32'h12345678, 4'b0101, 1'b1, 2'd3);
        chk("err_pulse", 64'(bus.err_keep), 64'd1);
        @(posedge clk);
        #1;
        chk("err_clear", 64'(bus.err_keep), 64'd0);
        exp_h(32'h12345678, 4'b1111);
        drain("err");

        // Header slot held full: next first beat must stall
        hdr_mode = 2;
        @(posedge clk);
        #2;
        pkt.delete(); add_word(32'hA1A2A3A4, 4);
        send_pkt(4);
        exp_h(32'hA1A2A3A4, 4'b1111);
        bus.valid_in         = 1'b1;
        bus.data_in          = 32'h01020304;
        bus.keep_in          = 4'b1111;
        bus.last_in          = 1'b0;
        bus.byte_extract_cnt = 2'd0;
        repeat (4) begin
            @(negedge clk);
            chk("hdr_stall_ready_in", 64'(bus.ready_in), 64'd0);
        end
        hdr_mode = 0;
        pkt.delete(); add_word(32'h01020304, 4); add_word(32'h05000000, 1);
        model_pkt(1);
        send_pkt(1);
        drain("hdr_bp");

        // Random packets, always-ready then random backpressure on both ports
        for (int m = 0; m < 2; m++) begin
            out_mode = m;
            hdr_mode = m;
            for (int p = 0; p < 30; p++) begin
                int h;
                int len;
                h   = $urandom_range(1, 4);
                len = $urandom_range(1, 14);
                pkt.delete();
                for (int j = 0; j < len; j++) pkt.push_back(8'($urandom));
                model_pkt(h);
                send_pkt(h);
            end
            drain(m == 0 ? "rand_full" : "rand_bp");
        end

        // Reset mid-BODY with a stalled payload beat
        out_mode = 2;
        hdr_mode = 0;
        @(posedge clk);
        #2;
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0, 2'd1);
        send_beat(32'h11223344, 4'b1111, 1'b0, 2'd0);
        exp_h(32'hAABB0000, 4'b1100);
        chk("mid_body_valid_out", 64'(bus.valid_out), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready_in", 64'(bus.ready_in), 64'd0);
        @(posedge clk);
        #1;
        check_reset_outputs("mid_rst");
        rst      = 1'b0;
        out_mode = 0;
        pkt.delete(); add_word(32'h5A6B7C8D, 4); add_word(32'h9EAF0000, 2);
        model_pkt(3);
        send_pkt(3);
        drain("post_rst");

        chk("stall_stability", 64'(stall_viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
